// File: rtl/driver_pkg.sv
// Shared definitions for the dot-driver command bus master: opcodes, FSM states,
// default phase timing and opcode classification helpers.
package driver_pkg;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_MEM_WRITE  = 3'd1;
  localparam logic [2:0] OP_DOT_WRITE  = 3'd2;
  localparam logic [2:0] OP_SEL_WRITE  = 3'd3;
  localparam logic [2:0] OP_SET_ROWCOL = 3'd4;
  localparam logic [2:0] OP_SET_OUTPUT = 3'd5;
  localparam logic [2:0] OP_SET_INVERT = 3'd6;
  localparam logic [2:0] OP_RESERVED   = 3'd7;

  localparam int DEF_MEM_ADDRESS_LENGTH = 6;
  localparam int DEF_SETUP_CYCLES       = 4;
  localparam int DEF_PULSE_CYCLES       = 8;
  localparam int DEF_HOLD_CYCLES        = 4;
  localparam int DEF_CNT_WIDTH          = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  function automatic logic is_strobe_op(input logic [2:0] op);
    return (op == OP_MEM_WRITE) || (op == OP_DOT_WRITE) || (op == OP_SEL_WRITE);
  endfunction

  function automatic logic is_level_op(input logic [2:0] op);
    return (op == OP_SET_ROWCOL) || (op == OP_SET_OUTPUT) || (op == OP_SET_INVERT);
  endfunction

endpackage

// File: rtl/driver_phase_timer.sv
// Loadable down-counter shared by the SETUP/STROBE/HOLD phases; done flags a
// zero count so the FSM can advance.
module driver_phase_timer #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  output logic                 done
);

  logic [CNT_WIDTH-1:0] cnt_r;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (load) begin
      cnt_r <= load_value;
    end else if (cnt_r != {CNT_WIDTH{1'b0}}) begin
      cnt_r <= cnt_r - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == {CNT_WIDTH{1'b0}});

endmodule

// File: rtl/driver_bus_master.sv
// Host-side transmitter for the dot-driver command bus: paces each command as
// setup -> strobe -> hold so the bit-wise synchronizing receiver never sees a torn word.
module driver_bus_master
  import driver_pkg::*;
#(
  parameter int MEM_ADDRESS_LENGTH = DEF_MEM_ADDRESS_LENGTH,
  parameter int SETUP_CYCLES       = DEF_SETUP_CYCLES,
  parameter int PULSE_CYCLES       = DEF_PULSE_CYCLES,
  parameter int HOLD_CYCLES        = DEF_HOLD_CYCLES,
  parameter int CNT_WIDTH          = DEF_CNT_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_op,
  input  logic [MEM_ADDRESS_LENGTH-1:0] cmd_addr,
  input  logic [MEM_ADDRESS_LENGTH-1:0] cmd_col,
  input  logic [2:0]                    cmd_mask,
  input  logic [15:0]                   cmd_data,
  output logic                          busy,
  output logic [2:0]                    mask_select,
  output logic [MEM_ADDRESS_LENGTH-1:0] mem_address,
  output logic [MEM_ADDRESS_LENGTH-1:0] row_select,
  output logic [MEM_ADDRESS_LENGTH-1:0] col_select,
  output logic [MEM_ADDRESS_LENGTH-1:0] mem_sel_col_address,
  output logic [15:0]                   data_in,
  output logic                          mem_write_n,
  output logic                          mem_dot_write_n,
  output logic                          mem_sel_write_n,
  output logic                          row_col_select,
  output logic                          output_active,
  output logic                          inverter_select
);

  state_t               state_r;
  state_t               next_state_s;
  logic [2:0]           op_r;
  logic                 accept_s;
  logic                 load_s;
  logic [CNT_WIDTH-1:0] load_value_s;
  logic                 done_s;

  driver_phase_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load_s),
    .load_value (load_value_s),
    .done       (done_s)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; NOP and reserved opcodes are consumed without leaving IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && is_strobe_op(cmd_op)) begin
          next_state_s = ST_SETUP;
        end else if (cmd_valid && is_level_op(cmd_op)) begin
          next_state_s = ST_HOLD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETUP:  next_state_s = done_s ? ST_STROBE : ST_SETUP;
      ST_STROBE: next_state_s = done_s ? ST_HOLD   : ST_STROBE;
      ST_HOLD:   next_state_s = done_s ? ST_IDLE   : ST_HOLD;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Handshake and phase-timer control.
  always_comb begin
    cmd_ready    = (state_r == ST_IDLE);
    busy         = !cmd_ready;
    accept_s     = cmd_valid && cmd_ready;
    load_s       = (next_state_s != state_r);
    load_value_s = {CNT_WIDTH{1'b0}};
    case (next_state_s)
      ST_SETUP:  load_value_s = CNT_WIDTH'(SETUP_CYCLES - 1);
      ST_STROBE: load_value_s = CNT_WIDTH'(PULSE_CYCLES - 1);
      ST_HOLD:   load_value_s = CNT_WIDTH'(HOLD_CYCLES - 1);
      default:   load_value_s = {CNT_WIDTH{1'b0}};
    endcase
  end

  // Bus fields and levels load only at acceptance, so they are frozen for the whole transaction.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      op_r                <= OP_NOP;
      mask_select         <= 3'd0;
      mem_address         <= {MEM_ADDRESS_LENGTH{1'b0}};
      row_select          <= {MEM_ADDRESS_LENGTH{1'b0}};
      col_select          <= {MEM_ADDRESS_LENGTH{1'b0}};
      mem_sel_col_address <= {MEM_ADDRESS_LENGTH{1'b0}};
      data_in             <= 16'd0;
      row_col_select      <= 1'b0;
      output_active       <= 1'b0;
      inverter_select     <= 1'b0;
    end else if (accept_s) begin
      op_r <= cmd_op;
      case (cmd_op)
        OP_MEM_WRITE: begin
          mem_address <= cmd_addr;
          mask_select <= cmd_mask;
          data_in     <= cmd_data;
        end
        OP_DOT_WRITE: begin
          row_select <= cmd_addr;
          col_select <= cmd_col;
        end
        OP_SEL_WRITE: begin
          mem_sel_col_address <= cmd_addr;
          data_in             <= cmd_data;
        end
        OP_SET_ROWCOL: row_col_select  <= cmd_data[0];
        OP_SET_OUTPUT: output_active   <= cmd_data[0];
        OP_SET_INVERT: inverter_select <= cmd_data[0];
        default: ;
      endcase
    end else begin
      op_r <= op_r;
    end
  end

  // Strobes follow the upcoming state so they are low for exactly the STROBE phase.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mem_write_n     <= 1'b1;
      mem_dot_write_n <= 1'b1;
      mem_sel_write_n <= 1'b1;
    end else begin
      mem_write_n     <= !((next_state_s == ST_STROBE) && (op_r == OP_MEM_WRITE));
      mem_dot_write_n <= !((next_state_s == ST_STROBE) && (op_r == OP_DOT_WRITE));
      mem_sel_write_n <= !((next_state_s == ST_STROBE) && (op_r == OP_SEL_WRITE));
    end
  end

endmodule

// File: tb/tb_driver_bus_master.sv
// Randomized bench for driver_bus_master against a timeline model: each accepted
// command is reduced to its acceptance edge, duration and strobe window.
module tb_driver_bus_master;

  localparam int MAL = 6;
  localparam int S   = 4;
  localparam int P   = 8;
  localparam int H   = 4;

  logic           clock = 1'b0;
  logic           reset_n = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [2:0]     cmd_op = 3'd0;
  logic [MAL-1:0] cmd_addr = '0;
  logic [MAL-1:0] cmd_col = '0;
  logic [2:0]     cmd_mask = 3'd0;
  logic [15:0]    cmd_data = 16'd0;
  logic           busy;
  logic [2:0]     mask_select;
  logic [MAL-1:0] mem_address, row_select, col_select, mem_sel_col_address;
  logic [15:0]    data_in;
  logic           mem_write_n, mem_dot_write_n, mem_sel_write_n;
  logic           row_col_select, output_active, inverter_select;

  driver_bus_master #(
    .MEM_ADDRESS_LENGTH(MAL), .SETUP_CYCLES(S), .PULSE_CYCLES(P),
    .HOLD_CYCLES(H), .CNT_WIDTH(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_col(cmd_col), .cmd_mask(cmd_mask),
    .cmd_data(cmd_data), .busy(busy), .mask_select(mask_select),
    .mem_address(mem_address), .row_select(row_select), .col_select(col_select),
    .mem_sel_col_address(mem_sel_col_address), .data_in(data_in),
    .mem_write_n(mem_write_n), .mem_dot_write_n(mem_dot_write_n),
    .mem_sel_write_n(mem_sel_write_n), .row_col_select(row_col_select),
    .output_active(output_active), .inverter_select(inverter_select)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: last acceptance edge/op/length plus architectural field values.
  int             edge_n = 0;
  int             acc_edge = -100;
  int             acc_len = 0;
  logic [2:0]     acc_op = 3'd0;
  logic           accepted = 1'b0;
  logic [2:0]     m_mask = 3'd0;
  logic [MAL-1:0] m_addr = '0, m_row = '0, m_col = '0, m_sel = '0;
  logic [15:0]    m_data = 16'd0;
  logic           m_rc = 1'b0, m_oa = 1'b0, m_inv = 1'b0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_edge();
    accepted = 1'b0;
    if (!reset_n) begin
      acc_edge = -100; acc_len = 0; acc_op = 3'd0;
      m_mask = 3'd0; m_addr = '0; m_row = '0; m_col = '0; m_sel = '0;
      m_data = 16'd0; m_rc = 1'b0; m_oa = 1'b0; m_inv = 1'b0;
    end else if (cmd_valid && edge_n > acc_edge + acc_len) begin
      accepted = 1'b1;
      acc_edge = edge_n;
      acc_op   = cmd_op;
      case (cmd_op)
        3'd1: begin m_addr = cmd_addr; m_mask = cmd_mask; m_data = cmd_data; acc_len = S + P + H; end
        3'd2: begin m_row = cmd_addr; m_col = cmd_col; acc_len = S + P + H; end
        3'd3: begin m_sel = cmd_addr; m_data = cmd_data; acc_len = S + P + H; end
        3'd4: begin m_rc = cmd_data[0]; acc_len = H; end
        3'd5: begin m_oa = cmd_data[0]; acc_len = H; end
        3'd6: begin m_inv = cmd_data[0]; acc_len = H; end
        default: acc_len = 0;
      endcase
    end
  endtask

  // One clock: model the edge, then compare everything at the falling edge.
  task automatic step();
    logic [63:0] exp_bus, obs_bus;
    logic        in_pulse;
    @(posedge clock);
    edge_n++;
    model_edge();
    @(negedge clock);
    in_pulse = (edge_n >= acc_edge + S) && (edge_n < acc_edge + S + P);
    exp_bus = {15'd0, !(in_pulse && acc_op == 3'd1), !(in_pulse && acc_op == 3'd2),
               !(in_pulse && acc_op == 3'd3), m_rc, m_oa, m_inv, m_mask,
               m_addr, m_row, m_col, m_sel, m_data};
    obs_bus = {15'd0, mem_write_n, mem_dot_write_n, mem_sel_write_n, row_col_select,
               output_active, inverter_select, mask_select, mem_address, row_select,
               col_select, mem_sel_col_address, data_in};
    check_value("bus", obs_bus, exp_bus);
    check_value("ready", {62'd0, busy, cmd_ready}, {62'd0, edge_n < acc_edge + acc_len, edge_n >= acc_edge + acc_len});
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Present a command and hold it until the model says it was taken.
  task automatic issue(input logic [2:0] op, input logic [MAL-1:0] addr, input logic [MAL-1:0] col,
                       input logic [2:0] mask, input logic [15:0] data, output int at);
    int n;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_col = col; cmd_mask = mask; cmd_data = data;
    n = 0;
    at = -1;
    while (!accepted && n < 100) begin
      step();
      n++;
    end
    if (!accepted) check_value("accept_timeout", 64'd0, 64'd1);
    else at = edge_n;
    accepted = 1'b0;
  endtask

  initial begin
    int a0, a1;
    // Reset with a command pending: nothing must be taken.
    reset_n = 1'b0;
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_addr = 6'h15; cmd_data = 16'h1234;
    step(); step();
    reset_n = 1'b1;
    idle(2);

    issue(3'd1, 6'h2A, 6'h00, 3'd5, 16'hBEEF, a0);
    idle(20);

    issue(3'd2, 6'd3, 6'd47, 3'd0, 16'h0000, a0);
    issue(3'd3, 6'd9, 6'd0, 3'd0, 16'h00FF, a1);
    check_value("b2b_gap", 64'(a1 - a0), 64'(S + P + H + 1));
    idle(20);

    issue(3'd5, 6'd0, 6'd0, 3'd0, 16'h0001, a0);
    issue(3'd6, 6'd0, 6'd0, 3'd0, 16'h0001, a1);
    check_value("level_gap", 64'(a1 - a0), 64'(H + 1));
    idle(6);

    // Reset landing in the middle of the strobe pulse.
    issue(3'd1, 6'h11, 6'h00, 3'd3, 16'hA5A5, a0);
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    issue(3'd3, 6'h22, 6'h00, 3'd0, 16'h5A5A, a0);
    idle(18);

    issue(3'd7, 6'h3F, 6'h3F, 3'd7, 16'hFFFF, a0);
    issue(3'd0, 6'h01, 6'h02, 3'd1, 16'h0001, a1);
    check_value("nop_gap", 64'(a1 - a0), 64'd1);
    idle(2);

    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end
      idle($urandom_range(0, 2));
      issue(3'($urandom_range(0, 7)), 6'($urandom), 6'($urandom), 3'($urandom),
            16'($urandom), a0);
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/driver_bus_master.md
Name: driver_bus_master

Overview:
- Host-side transmitter for the dot-driver command bus. Runs in the host clock domain and generates the mask, address, data, strobe and level signals that the driver core synchronizes bit-by-bit into its own clock domain.
- Because each bit is synchronized independently, the block paces every transaction. Data is set up first, then the strobe pulses, then data is held, so the receiver never samples a torn word.
- Accepts one command at a time over a valid/ready handshake.

Parameters:
- MEM_ADDRESS_LENGTH, 6, width of mem/row/col/sel-col address fields.
- SETUP_CYCLES, 4, cycles bus data is stable before strobe assertion (>=1).
- PULSE_CYCLES, 8, cycles a write_n strobe is held low (>=1).
- HOLD_CYCLES, 4, cycles data is held after strobe release / after a level change (>=1).
- CNT_WIDTH, 8, phase counter width; each cycle parameter must be < 2^CNT_WIDTH.

Ports:
- clock  in  1  host clock; sole clock of the block.
- reset_n  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle; command accepted when cmd_valid & cmd_ready.
- cmd_op  in  3  opcode (see Behaviour).
- cmd_addr  in  MEM_ADDRESS_LENGTH  mem_address / row_select / mem_sel_col_address per op.
- cmd_col  in  MEM_ADDRESS_LENGTH  col_select for DOT_WRITE.
- cmd_mask  in  3  mask_select for MEM_WRITE.
- cmd_data  in  16  data_in payload; bit0 is the level value for level ops.
- busy  out  1  ~cmd_ready.
- mask_select, mem_address, row_select, col_select, mem_sel_col_address, data_in  out  3/MAL/MAL/MAL/MAL/16  registered bus fields.
- mem_write_n, mem_dot_write_n, mem_sel_write_n  out  1  registered active-low strobes.
- row_col_select, output_active, inverter_select  out  1  registered levels.

Behaviour:
- Reset (reset_n=0 at a clock edge): all strobes=1; all bus fields and levels=0; state IDLE; counter 0; any in-flight command is discarded. A strobe that is low rises at that edge.
- Opcodes:
  - 0 NOP: accepted, no bus change, stays IDLE.
  - 1 MEM_WRITE: loads mem_address, mask_select, data_in; strobes mem_write_n.
  - 2 DOT_WRITE: loads row_select, col_select; strobes mem_dot_write_n.
  - 3 SEL_WRITE: loads mem_sel_col_address, data_in; strobes mem_sel_write_n.
  - 4 SET_ROWCOL, 5 SET_OUTPUT, 6 SET_INVERT: level ops; load row_col_select / output_active / inverter_select from cmd_data[0].
  - 7: reserved; treated as NOP.
- FSM states: IDLE, SETUP, STROBE, HOLD. cmd_ready=1 only in IDLE (combinational from state).
- Strobe op accepted at edge T0:
  - Fields update at T0; state goes to SETUP for SETUP_CYCLES cycles.
  - Selected strobe is 0 for exactly PULSE_CYCLES cycles (STROBE).
  - Strobe returns to 1, then HOLD for HOLD_CYCLES cycles, then IDLE.
  - cmd_ready reasserts SETUP+PULSE+HOLD cycles after acceptance (16 at defaults).
- Level op accepted at T0: level updates at T0 -> HOLD for HOLD_CYCLES -> IDLE. Fields not addressed by the op are untouched.
- Bus fields and levels retain their last value after a transaction; they never return to 0 except on reset.
- Only one strobe is ever low at a time. Fields never change while a strobe is low or during HOLD.
- Counter loads (phase length - 1) on each state entry and decrements; the state advances when the count is 0.
- cmd_valid while busy is ignored (not latched); the upstream holds the command.
- Back-to-back commands: the next command is accepted on the first IDLE cycle; there is no extra idle gap.

Decomposition:
- Shared package (driver_pkg): opcode localparams OP_NOP..OP_SET_INVERT, FSM state encoding, default timing constants.
- One natural sub-module: driver_phase_timer, a loadable down-counter with a done flag, shared by the SETUP/STROBE/HOLD phases.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with cmd_valid=1 -> all strobes 1, all fields and levels 0, cmd_ready=1 after release, no command accepted during reset.
- MEM_WRITE addr=0x2A, mask=5, data=0xBEEF (defaults) -> fields valid 4 cycles before mem_write_n falls; low for exactly 8 cycles; fields stable 4 cycles after it rises; cmd_ready returns 16 cycles after acceptance.
- DOT_WRITE row=3, col=47 immediately followed by SEL_WRITE addr=9, data=0x00FF held valid -> second command accepted on the first IDLE cycle; mem_dot_write_n and mem_sel_write_n never low simultaneously; row/col unchanged by SEL_WRITE.
- SET_OUTPUT data[0]=1 then SET_INVERT data[0]=1 -> output_active=1 at acceptance; inverter_select=1 exactly 5 cycles later; no strobe activity.
- reset_n=0 during STROBE of a MEM_WRITE -> mem_write_n=1 at that edge, fields=0, IDLE; the next command executes normally.
- Op 7 and NOP -> accepted in 1 cycle; no output change; cmd_ready stays 1.
